legv8_control_unit: RTL and testbench
=====================================

// Module: legv8_control_unit
// PURPOSE
//  Multi-cycle control FSM that drives the 34-bit ControlWord and 64-bit constant into the LEGv8 datapath.
//  Consumes the datapath's IR_out and status. Runs a FETCH/EXEC loop over a LEGv8 subset and stops in HALT on undefined opcodes.
//  Also exports a retired-instruction counter and a halt flag for visualization.
// PARAMETERS
//  FS_ADD  5'b01000  ALU FS code for add (C0=0) and subtract (C0=1, B inverted by ALU)
//  FS_AND  5'b00000  ALU FS code for bitwise AND
//  FS_OR   5'b00100  ALU FS code for bitwise OR
//  FS_PASSB 5'b01100 ALU FS code for output = B (used for CBZ/CBNZ zero test)
// PORTS
//  clock        in   1   system clock, all state updates on rising edge
//  reset        in   1   asynchronous, active-low reset
//  IR           in   32  instruction register contents from datapath
//  status       in   5   {V,C,N,Z} from status register in [4:1], live ALU Z in [0]
//  ControlWord  out  34  {AS,DS[1:0],PS[1:0],PCsel,Bsel,IL,SL,FS[4:0],C0,size[1:0],MW,RW,DA,SA,SB}
//  constant     out  64  immediate/offset presented to datapath B-mux and PC adder
//  instr_count  out  32  number of instructions retired since reset
//  halted       out  1   1 while FSM is in HALT
// BEHAVIOUR
//  State register: FETCH=2'd0, EXEC=2'd1, HALT=2'd2. Value 2'd3 is illegal and recovers to FETCH next cycle.
//  Reset (reset==0, async): state=FETCH, instr_count=0, halted=0.
//   ControlWord=34'h0 and constant=64'h0 while reset is low, so no IL/RW/MW/PS activity.
//  ControlWord and constant are combinational from state, IR and status. No registered output latency.
//  Encodings: AS 1=PC on address bus. DS 00 ALU, 01 B, 10 PC, 11 memory. Bsel 1=constant.
//   PS 00 hold, 01 PC+4, 10 PC+constant.
//   size 10 = 32-bit, 11 = 64-bit.
//  FETCH word: AS=1, DS=11, size=10, IL=1, PS=01. All else 0. Next state is EXEC.
//  EXEC decodes IR[31:21] (Rd/Rt=IR[4:0], Rn=IR[9:5], Rm=IR[20:16]):
//   ADD/SUB/AND/ORR/ADDS/SUBS (10001011000/11001011000/10001010000/10101010000/10101011000/11101011000):
//    DA=Rd, SA=Rn, SB=Rm, Bsel=0, DS=00, RW=1. SL=1 only for ADDS/SUBS. C0=1 for SUB/SUBS.
//   ADDI/SUBI (1001000100x/1101000100x): constant=zero-ext IR[21:10], Bsel=1, DA=Rd, SA=Rn, DS=00, RW=1.
//   LDUR (11111000010): constant=sign-ext IR[20:12], Bsel=1, FS_ADD, AS=0, DS=11, size=11, RW=1, DA=Rt, SA=Rn.
//   STUR (11111000000): same address as LDUR, SB=Rt, DS=01, MW=1, RW=0.
//   B (000101xxxxx): constant = sext(IR[25:0])<<2 minus 4 (PC already advanced in FETCH), PS=10.
//   CBZ/CBNZ (10110100xxx/10110101xxx): SB=Rt, FS_PASSB, constant = sext(IR[23:5])<<2 minus 4.
//    PS=10 if status[0] (CBZ) or !status[0] (CBNZ), else PS=00.
//   B.cond (01010100xxx): cond=IR[3:0], evaluated on status[4:1]. Standard ARM table for 0x0-0xD.
//    0xE/0xF always branch. Taken: PS=10 with the CBZ offset; not taken: PS=00.
//  Every legal EXEC returns to FETCH and increments instr_count (wraps 32'hFFFFFFFF -> 0).
//  Any other opcode: EXEC word is all-zero (no writes), next state HALT, instr_count unchanged.
//  HALT: ControlWord=0, halted=1. Stays in HALT until reset. Only reset leaves HALT.
//  Reset asserted mid-EXEC aborts immediately: outputs go to 0 asynchronously, no partial write occurs at the next edge.
//  status is sampled only in EXEC. Flags set by ADDS/SUBS are visible to an immediately following B.cond.
// TESTING
//  Reset low then release: first ControlWord = FETCH word (IL=1, PS=01, AS=1, DS=11); instr_count=0, halted=0.
//  IR=ADD X3,X1,X2 (32'h8B020023) in EXEC -> DA=3, SA=1, SB=2, RW=1, DS=00, FS=FS_ADD, C0=0; instr_count -> 1.
//  IR=LDUR X5,[X6,#-8] (32'hF85F80C5) -> constant=64'hFFFFFFFFFFFFFFF8, Bsel=1, DS=11, size=11, RW=1, DA=5.
//  IR=CBZ X4,#+16 (32'hB4000084): status[0]=1 -> PS=10, constant=12; status[0]=0 -> PS=00.
//  SUBS then B.EQ with status[4:1]=4'b0001 -> PS=10; with status[4:1]=4'b0000 -> PS=00.
//  IR=32'h00000000 -> next HALT, halted=1, ControlWord=0 held for 10 cycles; reset low clears halted.

Source files
------------

// File: rtl/legv8_control_unit_if.sv
// Control-unit <-> datapath bundle: instruction/status in,
// control word, constant and visualization outputs back.
interface legv8_control_unit_if;
    logic [31:0] IR;
    logic [4:0]  status;
    logic [33:0] ControlWord;
    logic [63:0] constant;
    logic [31:0] instr_count;
    logic        halted;

    modport master (
        input  IR,
        input  status,
        output ControlWord,
        output constant,
        output instr_count,
        output halted
    );

    modport slave (
        output IR,
        output status,
        input  ControlWord,
        input  constant,
        input  instr_count,
        input  halted
    );
endinterface

// File: rtl/legv8_control_unit.sv
// Multi-cycle LEGv8 control FSM: FETCH/EXEC loop over a subset,
// parks in HALT on any undefined opcode until reset.
module legv8_control_unit (
    input  logic                   clock,
    input  logic                   reset,
    legv8_control_unit_if.master   bus
);
    localparam logic [4:0] FS_ADD   = 5'b01000;
    localparam logic [4:0] FS_AND   = 5'b00000;
    localparam logic [4:0] FS_OR    = 5'b00100;
    localparam logic [4:0] FS_PASSB = 5'b01100;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2,
        BAD   = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;

    logic [31:0] ir;
    logic [10:0] op;
    logic [4:0]  rd, rn, rm;
    logic        v_f, c_f, n_f, z_f;
    assign ir  = bus.IR;
    assign op  = ir[31:21];
    assign rd  = ir[4:0];
    assign rn  = ir[9:5];
    assign rm  = ir[20:16];
    assign v_f = bus.status[4];
    assign c_f = bus.status[3];
    assign n_f = bus.status[2];
    assign z_f = bus.status[1];

    logic k_add, k_sub, k_and, k_orr, k_adds, k_subs;
    logic k_addi, k_subi, k_ldur, k_stur;
    logic k_b, k_cbz, k_cbnz, k_bcond;
    logic k_rtype, legal;

    assign k_add   = op == 11'b10001011000;
    assign k_sub   = op == 11'b11001011000;
    assign k_and   = op == 11'b10001010000;
    assign k_orr   = op == 11'b10101010000;
    assign k_adds  = op == 11'b10101011000;
    assign k_subs  = op == 11'b11101011000;
    assign k_addi  = op[10:1] == 10'b1001000100;
    assign k_subi  = op[10:1] == 10'b1101000100;
    assign k_ldur  = op == 11'b11111000010;
    assign k_stur  = op == 11'b11111000000;
    assign k_b     = op[10:5] == 6'b000101;
    assign k_cbz   = op[10:3] == 8'b10110100;
    assign k_cbnz  = op[10:3] == 8'b10110101;
    assign k_bcond = op[10:3] == 8'b01010100;

    assign k_rtype = k_add | k_sub | k_and | k_orr
                   | k_adds | k_subs;
    assign legal   = k_rtype | k_addi | k_subi | k_ldur
                   | k_stur | k_b | k_cbz | k_cbnz | k_bcond;

    // Branch offsets are relative to the already-advanced PC
    logic [63:0] off19, off26, dt9;
    assign off19 = {{43{ir[23]}}, ir[23:5], 2'b00} - 64'd4;
    assign off26 = {{36{ir[25]}}, ir[25:0], 2'b00} - 64'd4;
    assign dt9   = {{55{ir[20]}}, ir[20:12]};

    logic cond_ok;
    always_comb begin
        cond_ok = 1'b0;
        unique case (ir[3:0])
            4'h0: cond_ok = z_f;
            4'h1: cond_ok = !z_f;
            4'h2: cond_ok = c_f;
            4'h3: cond_ok = !c_f;
            4'h4: cond_ok = n_f;
            4'h5: cond_ok = !n_f;
            4'h6: cond_ok = v_f;
            4'h7: cond_ok = !v_f;
            4'h8: cond_ok = c_f && !z_f;
            4'h9: cond_ok = !(c_f && !z_f);
            4'hA: cond_ok = n_f == v_f;
            4'hB: cond_ok = n_f != v_f;
            4'hC: cond_ok = !z_f && (n_f == v_f);
            4'hD: cond_ok = !(!z_f && (n_f == v_f));
            4'hE: cond_ok = 1'b1;
            4'hF: cond_ok = 1'b1;
        endcase
    end

    logic        as_, pcsel, bsel, il, sl, c0, mw, rw;
    logic [1:0]  ds, ps, size;
    logic [4:0]  fs, da, sa, sb;
    logic [63:0] k;
    logic        br_t;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        as_ = 1'b0; pcsel = 1'b0; bsel = 1'b0; il = 1'b0;
        sl  = 1'b0; c0 = 1'b0; mw = 1'b0; rw = 1'b0;
        ds  = 2'b00; ps = 2'b00; size = 2'b00;
        fs  = 5'd0; da = 5'd0; sa = 5'd0; sb = 5'd0;
        k   = 64'd0;
        br_t = 1'b0;
        unique case (state_q)
            FETCH: begin
                as_  = 1'b1;
                ds   = 2'b11;
                size = 2'b10;
                il   = 1'b1;
                ps   = 2'b01;
                state_d = EXEC;
            end
            EXEC: begin
                state_d = legal ? FETCH : HALT;
                if (legal) cnt_d = cnt_q + 32'd1;
                unique case (1'b1)
                    k_rtype: begin
                        da = rd; sa = rn; sb = rm; rw = 1'b1;
                        sl = k_adds | k_subs;
                        c0 = k_sub | k_subs;
                        fs = k_and ? FS_AND :
                             k_orr ? FS_OR : FS_ADD;
                    end
                    k_addi, k_subi: begin
                        k    = {52'd0, ir[21:10]};
                        bsel = 1'b1; fs = FS_ADD; c0 = k_subi;
                        da = rd; sa = rn; rw = 1'b1;
                    end
                    k_ldur: begin
                        k    = dt9; bsel = 1'b1; fs = FS_ADD;
                        ds   = 2'b11; size = 2'b11; rw = 1'b1;
                        da = rd; sa = rn;
                    end
                    k_stur: begin
                        k    = dt9; bsel = 1'b1; fs = FS_ADD;
                        ds   = 2'b01; size = 2'b11; mw = 1'b1;
                        sa = rn; sb = rd;
                    end
                    k_b: begin
                        k  = off26;
                        ps = 2'b10;
                    end
                    k_cbz, k_cbnz: begin
                        sb = rd; fs = FS_PASSB; k = off19;
                        br_t = k_cbz ? bus.status[0]
                                     : !bus.status[0];
                        ps = br_t ? 2'b10 : 2'b00;
                    end
                    k_bcond: begin
                        k  = off19;
                        ps = cond_ok ? 2'b10 : 2'b00;
                    end
                    default: ;
                endcase
            end
            HALT: ;
            BAD: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    logic [33:0] cw;
    assign cw = {as_, ds, ps, pcsel, bsel, il, sl, fs, c0,
                 size, mw, rw, da, sa, sb};

    // Gate with reset so an aborted EXEC cannot strobe writes
    assign bus.ControlWord = reset ? cw : 34'd0;
    assign bus.constant    = reset ? k : 64'd0;
    assign bus.instr_count = cnt_q;
    assign bus.halted      = state_q == HALT;
endmodule

// File: tb/tb_legv8_control_unit.sv
// Bench for legv8_control_unit: directed vector table, corner
// sequences and random instructions against a decode model.
module tb_legv8_control_unit;
    localparam int FS_ADD   = 8;
    localparam int FS_AND   = 0;
    localparam int FS_OR    = 4;
    localparam int FS_PASSB = 12;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    legv8_control_unit_if bus();

    legv8_control_unit dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [33:0] cw;
        logic [63:0] k;
        bit          legal;
    } exp_t;

    typedef struct {
        string       nm;
        logic [31:0] ir;
        logic [4:0]  st;
        logic [33:0] cw;
        logic [63:0] k;
    } vec_t;

    vec_t tbl[$];

    localparam bit [10:0] OPM [14] = '{
        11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF,
        11'h7FE, 11'h7FE, 11'h7FF, 11'h7FF, 11'h7E0,
        11'h7F8, 11'h7F8, 11'h7F8};
    localparam bit [10:0] OPV [14] = '{
        11'h458, 11'h658, 11'h450, 11'h550, 11'h558, 11'h758,
        11'h488, 11'h688, 11'h7C2, 11'h7C0, 11'h0A0,
        11'h5A0, 11'h5A8, 11'h2A0};

    function automatic logic [33:0] pk(
        int a, int ds, int ps, int bs, int il, int sl, int fs,
        int c0, int sz, int mw, int rw, int da, int sa, int sb);
        return {1'(a), 2'(ds), 2'(ps), 1'b0, 1'(bs), 1'(il),
                1'(sl), 5'(fs), 1'(c0), 2'(sz), 1'(mw), 1'(rw),
                5'(da), 5'(sa), 5'(sb)};
    endfunction

    function automatic bit cond(logic [3:0] c, logic [4:0] st);
        bit v = st[4];
        bit cy = st[3];
        bit n = st[2];
        bit z = st[1];
        bit r = 1'b0;
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (c[0] && c != 4'hF) r = !r;
        return r;
    endfunction

    function automatic exp_t model(logic [31:0] ir,
                                   logic [4:0] st);
        exp_t e;
        int id = -1;
        int rd = int'(ir[4:0]);
        int rn = int'(ir[9:5]);
        int rm = int'(ir[20:16]);
        longint s9, s19, s26;
        bit tk;
        e.cw = '0;
        e.k = '0;
        for (int i = 0; i < 14; i++)
            if ((ir[31:21] & OPM[i]) == OPV[i]) id = i;
        e.legal = id >= 0;
        s9 = longint'(ir[20:12]);
        if (ir[20]) s9 -= 512;
        s19 = longint'(ir[23:5]);
        if (ir[23]) s19 -= 524288;
        s26 = longint'(ir[25:0]);
        if (ir[25]) s26 -= 67108864;
        case (id)
            0, 1, 2, 3, 4, 5:
                e.cw = pk(0, 0, 0, 0, 0, int'(id >= 4),
                          id == 2 ? FS_AND :
                          id == 3 ? FS_OR : FS_ADD,
                          int'(id == 1 || id == 5),
                          0, 0, 1, rd, rn, rm);
            6, 7: begin
                e.cw = pk(0, 0, 0, 1, 0, 0, FS_ADD,
                          int'(id == 7), 0, 0, 1, rd, rn, 0);
                e.k = 64'(ir[21:10]);
            end
            8: begin
                e.cw = pk(0, 3, 0, 1, 0, 0, FS_ADD, 0, 3, 0, 1,
                          rd, rn, 0);
                e.k = 64'(s9);
            end
            9: begin
                e.cw = pk(0, 1, 0, 1, 0, 0, FS_ADD, 0, 3, 1, 0,
                          0, rn, rd);
                e.k = 64'(s9);
            end
            10: begin
                e.cw = pk(0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                e.k = 64'(s26 * 4 - 4);
            end
            11, 12: begin
                tk = (id == 11) == st[0];
                e.cw = pk(0, 0, tk ? 2 : 0, 0, 0, 0, FS_PASSB,
                          0, 0, 0, 0, 0, 0, rd);
                e.k = 64'(s19 * 4 - 4);
            end
            13: begin
                tk = cond(ir[3:0], st);
                e.cw = pk(0, 0, tk ? 2 : 0, 0, 0, 0, 0,
                          0, 0, 0, 0, 0, 0, 0);
                e.k = 64'(s19 * 4 - 4);
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    logic [33:0] fetch_w;

    task automatic run(input string nm, input logic [31:0] ir,
                       input logic [4:0] st, input logic [33:0] ecw,
                       input logic [63:0] ek, input bit el);
        chk({nm, "_fetch"}, 64'(bus.ControlWord), 64'(fetch_w));
        @(posedge clk); #1;
        bus.IR = ir;
        bus.status = st;
        #1;
        chk({nm, "_cw"}, 64'(bus.ControlWord), 64'(ecw));
        chk({nm, "_k"}, bus.constant, ek);
        @(posedge clk); #1;
        if (el) exp_cnt++;
        chk({nm, "_cnt"}, 64'(bus.instr_count), 64'(exp_cnt));
        chk({nm, "_halt"}, 64'(bus.halted), 64'(!el));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_halt", 64'(bus.halted), 64'd0);
        chk("rst_cnt", 64'(bus.instr_count), 64'd0);
        rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    initial begin
        exp_t m;
        logic [31:0] r, ir;
        logic [4:0] st;
        fetch_w = pk(1, 3, 1, 0, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0);

        tbl.push_back('{"add", 32'h8B020023, 5'd0,
            pk(0,0,0,0,0,0,FS_ADD,0,0,0,1,3,1,2), 64'd0});
        tbl.push_back('{"ldur", 32'hF85F80C5, 5'd0,
            pk(0,3,0,1,0,0,FS_ADD,0,3,0,1,5,6,0),
            64'hFFFFFFFFFFFFFFF8});
        tbl.push_back('{"cbz_t", 32'hB4000084, 5'b00001,
            pk(0,0,2,0,0,0,FS_PASSB,0,0,0,0,0,0,4), 64'd12});
        tbl.push_back('{"cbz_nt", 32'hB4000084, 5'b11110,
            pk(0,0,0,0,0,0,FS_PASSB,0,0,0,0,0,0,4), 64'd12});
        tbl.push_back('{"cbnz_t", 32'hB5000084, 5'b00000,
            pk(0,0,2,0,0,0,FS_PASSB,0,0,0,0,0,0,4), 64'd12});
        tbl.push_back('{"subs", {11'h758, 5'd3, 6'd0, 5'd2, 5'd1},
            5'd0, pk(0,0,0,0,0,1,FS_ADD,1,0,0,1,1,2,3), 64'd0});
        tbl.push_back('{"beq_t", 32'h54000040, 5'b00010,
            pk(0,0,2,0,0,0,0,0,0,0,0,0,0,0), 64'd4});
        tbl.push_back('{"beq_nt", 32'h54000040, 5'b00000,
            pk(0,0,0,0,0,0,0,0,0,0,0,0,0,0), 64'd4});
        tbl.push_back('{"bgt_t", 32'h5400004C, 5'b10100,
            pk(0,0,2,0,0,0,0,0,0,0,0,0,0,0), 64'd4});
        tbl.push_back('{"addi", {10'h244, 12'hFFF, 5'd8, 5'd7},
            5'd0, pk(0,0,0,1,0,0,FS_ADD,0,0,0,1,7,8,0),
            64'hFFF});
        tbl.push_back('{"stur", {11'h7C0, 9'd16, 2'b00, 5'd10,
            5'd9}, 5'd0, pk(0,1,0,1,0,0,FS_ADD,0,3,1,0,0,10,9),
            64'd16});
        tbl.push_back('{"b_back", 32'h17FFFFFF, 5'd0,
            pk(0,0,2,0,0,0,0,0,0,0,0,0,0,0),
            64'hFFFFFFFFFFFFFFF8});
        tbl.push_back('{"orr", {11'h550, 5'd3, 6'd0, 5'd2, 5'd1},
            5'd0, pk(0,0,0,0,0,0,FS_OR,0,0,0,1,1,2,3), 64'd0});

        rst_n = 1'b0;
        bus.IR = 32'h8B020023;
        bus.status = 5'h1F;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cw", 64'(bus.ControlWord), 64'd0);
        chk("rst_k", bus.constant, 64'd0);
        chk("rst_halt", 64'(bus.halted), 64'd0);
        chk("rst_cnt", 64'(bus.instr_count), 64'd0);
        rst_n = 1'b1;
        #1;

        foreach (tbl[i])
            run(tbl[i].nm, tbl[i].ir, tbl[i].st, tbl[i].cw,
                tbl[i].k, 1'b1);

        // Reset in the middle of EXEC must kill the word at once
        @(posedge clk); #1;
        bus.IR = 32'h8B020023;
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_cw", 64'(bus.ControlWord), 64'd0);
        chk("abort_k", bus.constant, 64'd0);
        @(posedge clk); #1;
        chk("abort_cnt", 64'(bus.instr_count), 64'd0);
        rst_n = 1'b1;
        exp_cnt = 0;
        #1;

        run("ill", 32'h00000000, 5'd0, 34'd0, 64'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("halt_cw", 64'(bus.ControlWord), 64'd0);
            chk("halt_flag", 64'(bus.halted), 64'd1);
            chk("halt_cnt", 64'(bus.instr_count), 64'(exp_cnt));
        end
        do_reset();
        #1;

        for (int n = 0; n < 300; n++) begin
            r = $urandom;
            st = 5'($urandom);
            case ($urandom_range(0, 12))
                0: ir = {11'h458, r[20:0]};
                1: ir = {11'h658, r[20:0]};
                2: ir = {11'h450, r[20:0]};
                3: ir = {11'h550, r[20:0]};
                4: ir = {11'h558, r[20:0]};
                5: ir = {11'h758, r[20:0]};
                6: ir = {r[31] ? 10'h344 : 10'h244, r[21:0]};
                7: ir = {11'h7C2, r[20:0]};
                8: ir = {11'h7C0, r[20:0]};
                9: ir = {6'b000101, r[25:0]};
                10: ir = {7'b1011010, r[24:0]};
                11: ir = {8'h54, r[23:0]};
                default: ir = r;
            endcase
            m = model(ir, st);
            run("rnd", ir, st, m.cw, m.k, m.legal);
            if (!m.legal) begin
                repeat (2) begin
                    @(posedge clk); #1;
                    chk("rnd_halt", 64'(bus.ControlWord), 64'd0);
                end
                do_reset();
                #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
